hash_sequencer: RTL and testbench

HASH_SEQUENCER -- requirements
Module: hash_sequencer

---
 rtl/hash_sequencer_pkg.sv | 42 ++++
 rtl/hash_sequencer_word_index.sv | 35 +++
 rtl/hash_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_hash_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hash_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// hash_sequencer_pkg
// Shared definitions for the hash block sequencer: hash mode and FSM state
// encodings, plus the per-mode last-round and digest-length tables.
// No ports (package).
// ----------------------------------------------------------------------------
package hash_sequencer_pkg;

   typedef enum logic [1:0] {
      OP_MD5    = 2'b00,
      OP_SHA1   = 2'b01,
      OP_SHA256 = 2'b10,
      OP_RSVD   = 2'b11
   } hash_op_e;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_COMPUTE = 3'd2,
      ST_FINAL   = 3'd3,
      ST_WRITE   = 3'd4,
      ST_DONE    = 3'd5
   } seq_state_e;

   // Index of the last compression round for each mode.
   function automatic logic [6:0] last_round(input hash_op_e op);
      case (op)
         OP_SHA1: last_round = 7'd79;
         default: last_round = 7'd63;
      endcase
   endfunction

   // Index of the last digest word (digest length minus one) for each mode.
   function automatic logic [2:0] last_digest_word(input hash_op_e op);
      case (op)
         OP_SHA1:   last_digest_word = 3'd4;
         OP_SHA256: last_digest_word = 3'd7;
         default:   last_digest_word = 3'd3;
      endcase
   endfunction

endpackage

// File: rtl/hash_sequencer_word_index.sv
// ----------------------------------------------------------------------------
// hash_word_index
// Combinational message-schedule index: which of the 16 block words feeds the
// current round.
// Ports:
//   opcode   in  hash mode
//   round    in  current round number
//   word_idx out message word index (0..15)
// ----------------------------------------------------------------------------
module hash_word_index
   import hash_sequencer_pkg::*;
#(
   parameter int RND_W = 7
) (
   input  hash_op_e         opcode,
   input  logic [RND_W-1:0] round,
   output logic [3:0]       word_idx
);

   logic [3:0] w_r4;

   // Every MD5 index formula is taken mod 16, so only round[3:0] matters.
   assign w_r4 = round[3:0];

   always_comb begin
      word_idx = w_r4;
      if (opcode == OP_MD5) begin
         if (round < RND_W'(16))      word_idx = w_r4;
         else if (round < RND_W'(32)) word_idx = 4'(w_r4 * 4'd5 + 4'd1);
         else if (round < RND_W'(48)) word_idx = 4'(w_r4 * 4'd3 + 4'd5);
         else                         word_idx = 4'(w_r4 * 4'd7);
      end
   end

endmodule

// File: rtl/hash_sequencer.sv
// ----------------------------------------------------------------------------
// hash_sequencer
// Control sequencer for an MD5/SHA1/SHA256 engine: fetches message words per
// round, paces the hash datapath, folds each block and writes the digest.
// Ports:
//   clk, reset_en          clock, asynchronous active-low reset
//   start, abort           job request (IDLE only) / cancel job
//   opcode                 00 MD5, 01 SHA1, 10 SHA256, 11 reserved
//   message_addr           message base word address
//   output_addr            digest base word address
//   num_blocks             number of 512-bit blocks
//   mem_ready              memory accepts this cycle (0 = stall)
//   mem_addr/read/write    memory word address and strobes
//   word_idx, round, chunk schedule index, round and block counters
//   digest_sel             digest word being written
//   hash_en, chunk_done    datapath advance / fold into digest
//   busy, done, err        job active / completion pulse / reserved-op pulse
// ----------------------------------------------------------------------------
module hash_sequencer
   import hash_sequencer_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int BLK_W  = 16,
   parameter int RND_W  = 7
) (
   input  logic              clk,
   input  logic              reset_en,
   input  logic              start,
   input  logic              abort,
   input  logic [1:0]        opcode,
   input  logic [ADDR_W-1:0] message_addr,
   input  logic [ADDR_W-1:0] output_addr,
   input  logic [BLK_W-1:0]  num_blocks,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_read,
   output logic              mem_write,
   output logic [3:0]        word_idx,
   output logic [RND_W-1:0]  round,
   output logic [BLK_W-1:0]  chunk,
   output logic [2:0]        digest_sel,
   output logic              hash_en,
   output logic              chunk_done,
   output logic              busy,
   output logic              done,
   output logic              err
);

   seq_state_e        r_state, w_state_nxt;
   hash_op_e          r_op;
   logic [RND_W-1:0]  r_round, w_round_nxt;
   logic [BLK_W-1:0]  r_chunk, w_chunk_nxt, w_chunk_inc;
   logic [2:0]        r_dsel, w_dsel_nxt;
   logic              r_err, w_err_nxt;
   logic              w_latch;
   logic [ADDR_W-1:0] r_msg_base, r_out_base;
   logic [BLK_W-1:0]  r_num_blocks;
   logic [3:0]        w_widx;
   logic [ADDR_W-1:0] w_rd_addr;

   hash_word_index #(.RND_W(RND_W)) u_word_index (
      .opcode   (r_op),
      .round    (r_round),
      .word_idx (w_widx)
   );

   // Block offset is chunk*16 words; the sum wraps at the address width.
   assign w_rd_addr   = r_msg_base + ADDR_W'({r_chunk, 4'b0000}) + ADDR_W'(w_widx);
   assign w_chunk_inc = r_chunk + BLK_W'(1);

   assign round      = r_round;
   assign chunk      = r_chunk;
   assign digest_sel = r_dsel;
   assign busy       = (r_state != ST_IDLE);
   assign err        = r_err;

   always_ff @(posedge clk or negedge reset_en) begin
      if (!reset_en) begin
         r_state <= ST_IDLE;
         r_op    <= OP_MD5;
         r_round <= '0;
         r_chunk <= '0;
         r_dsel  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_round <= w_round_nxt;
         r_chunk <= w_chunk_nxt;
         r_dsel  <= w_dsel_nxt;
         r_err   <= w_err_nxt;
         if (w_latch) r_op <= hash_op_e'(opcode);
      end
   end

   // Job parameters: only ever observed through state-gated outputs, so they
   // need no reset.
   always_ff @(posedge clk) begin
      if (w_latch) begin
         r_msg_base   <= message_addr;
         r_out_base   <= output_addr;
         r_num_blocks <= num_blocks;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_round_nxt = r_round;
      w_chunk_nxt = r_chunk;
      w_dsel_nxt  = r_dsel;
      w_err_nxt   = 1'b0;
      w_latch     = 1'b0;
      mem_addr    = '0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      word_idx    = '0;
      hash_en     = 1'b0;
      chunk_done  = 1'b0;
      done        = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (start) begin
               if (hash_op_e'(opcode) == OP_RSVD) begin
                  w_err_nxt = 1'b1;
               end else begin
                  w_latch     = 1'b1;
                  w_round_nxt = '0;
                  w_chunk_nxt = '0;
                  w_dsel_nxt  = '0;
                  w_state_nxt = (num_blocks != '0) ? ST_LOAD : ST_WRITE;
               end
            end
         end
         ST_LOAD: begin
            mem_read    = 1'b1;
            mem_addr    = w_rd_addr;
            word_idx    = w_widx;
            w_state_nxt = ST_COMPUTE;
         end
         ST_COMPUTE: begin
            mem_addr = w_rd_addr;
            word_idx = w_widx;
            // SHA expands rounds 16+ from its own schedule; MD5 re-reads words.
            mem_read = (r_op == OP_MD5) || (r_round < RND_W'(16));
            hash_en  = mem_ready;
            if (mem_ready) begin
               if (r_round == RND_W'(last_round(r_op))) begin
                  w_round_nxt = '0;
                  w_state_nxt = ST_FINAL;
               end else begin
                  w_round_nxt = r_round + RND_W'(1);
               end
            end
         end
         ST_FINAL: begin
            chunk_done  = 1'b1;
            w_chunk_nxt = w_chunk_inc;
            w_state_nxt = (w_chunk_inc < r_num_blocks) ? ST_LOAD : ST_WRITE;
         end
         ST_WRITE: begin
            mem_write = 1'b1;
            mem_addr  = r_out_base + ADDR_W'(r_dsel);
            if (mem_ready) begin
               if (r_dsel == last_digest_word(r_op)) begin
                  w_dsel_nxt  = '0;
                  w_state_nxt = ST_DONE;
               end else begin
                  w_dsel_nxt  = r_dsel + 3'd1;
               end
            end
         end
         ST_DONE: begin
            done        = 1'b1;
            w_chunk_nxt = '0;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      // Abort wins over everything: no datapath advance, no completion, and
      // every counter returns to zero.
      if (abort && (r_state != ST_IDLE)) begin
         hash_en     = 1'b0;
         chunk_done  = 1'b0;
         done        = 1'b0;
         w_state_nxt = ST_IDLE;
         w_round_nxt = '0;
         w_chunk_nxt = '0;
         w_dsel_nxt  = '0;
      end
   end

endmodule

// File: tb/tb_hash_sequencer.sv
// ----------------------------------------------------------------------------
// tb_hash_sequencer
// Directed self-checking bench for hash_sequencer.
// ----------------------------------------------------------------------------
module tb_hash_sequencer;

   localparam int ADDR_W = 16;
   localparam int BLK_W  = 16;
   localparam int RND_W  = 7;

   logic              clk = 1'b0;
   logic              reset_en = 1'b1;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic [1:0]        opcode = 2'b00;
   logic [ADDR_W-1:0] message_addr = '0;
   logic [ADDR_W-1:0] output_addr = '0;
   logic [BLK_W-1:0]  num_blocks = '0;
   logic              mem_ready = 1'b1;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_read;
   logic              mem_write;
   logic [3:0]        word_idx;
   logic [RND_W-1:0]  round;
   logic [BLK_W-1:0]  chunk;
   logic [2:0]        digest_sel;
   logic              hash_en;
   logic              chunk_done;
   logic              busy;
   logic              done;
   logic              err;

   hash_sequencer #(.ADDR_W(ADDR_W), .BLK_W(BLK_W), .RND_W(RND_W)) dut (
      .clk          (clk),
      .reset_en     (reset_en),
      .start        (start),
      .abort        (abort),
      .opcode       (opcode),
      .message_addr (message_addr),
      .output_addr  (output_addr),
      .num_blocks   (num_blocks),
      .mem_ready    (mem_ready),
      .mem_addr     (mem_addr),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .word_idx     (word_idx),
      .round        (round),
      .chunk        (chunk),
      .digest_sel   (digest_sel),
      .hash_en      (hash_en),
      .chunk_done   (chunk_done),
      .busy         (busy),
      .done         (done),
      .err          (err)
   );

   always #5 clk = ~clk;

   logic [63:0] all_outs;
   assign all_outs = 64'({mem_addr, mem_read, mem_write, word_idx, round, chunk,
                          digest_sel, hash_en, chunk_done, busy, done, err});

   int total = 0;
   int bad   = 0;

   // Per-job observations
   int          n_busy, n_hash, n_cd, n_done, n_err, n_wr, n_rd_acc, n_rd_hi;
   int          n_stall, n_frz_bad;
   logic [15:0] first_wr, last_wr, a_r0, a_r8, a_r15, a_r17, a_b2;
   logic        c1_rd, c1_he, c1_wr;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic launch(input logic [1:0] op, input logic [15:0] ma,
                         input logic [15:0] oa, input logic [15:0] nb);
      opcode       = op;
      message_addr = ma;
      output_addr  = oa;
      num_blocks   = nb;
      mem_ready    = 1'b1;
      start        = 1'b1;
   endtask

   // Watch a job cycle by cycle until busy drops (or stop_round is accepted).
   // Inputs are scrambled and start re-pulsed mid-job; neither may matter.
   task automatic run_job(input bit toggle, input int stop_round);
      int   n_cyc;
      logic stall_now, p_stall, p_rd, p_wr;
      logic [RND_W-1:0] p_round;
      logic [BLK_W-1:0] p_chunk;
      logic [2:0]       p_ds;
      n_cyc = 0; n_busy = 0; n_hash = 0; n_cd = 0; n_done = 0; n_err = 0;
      n_wr = 0; n_rd_acc = 0; n_rd_hi = 0; n_stall = 0; n_frz_bad = 0;
      first_wr = 'x; last_wr = 'x; a_r0 = 'x; a_r8 = 'x; a_r15 = 'x;
      a_r17 = 'x; a_b2 = 'x; c1_rd = 'x; c1_he = 'x; c1_wr = 'x;
      p_stall = 1'b0; p_rd = 1'b0; p_wr = 1'b0; p_round = '0; p_chunk = '0; p_ds = '0;
      while (n_cyc < 400) begin
         @(posedge clk); #1;
         n_cyc++;
         start = (n_cyc == 5);
         if (n_cyc == 1) begin
            opcode = 2'b11; message_addr = 16'hDEAD; output_addr = 16'hBEEF; num_blocks = 16'h7;
         end
         mem_ready = toggle ? n_cyc[0] : 1'b1;
         @(negedge clk);
         if (!busy) break;
         n_busy++;
         if (n_busy == 1) begin c1_rd = mem_read; c1_he = hash_en; c1_wr = mem_write; end
         if (hash_en) n_hash++;
         if (chunk_done) n_cd++;
         if (done) n_done++;
         if (err) n_err++;
         if (mem_write && mem_ready) begin
            if (n_wr == 0) first_wr = mem_addr;
            last_wr = mem_addr;
            n_wr++;
         end
         if (hash_en && mem_read) n_rd_acc++;
         if (mem_read && round >= 16) n_rd_hi++;
         if (hash_en && chunk == 0 && round == 0)  a_r0  = mem_addr;
         if (hash_en && chunk == 0 && round == 8)  a_r8  = mem_addr;
         if (hash_en && chunk == 0 && round == 15) a_r15 = mem_addr;
         if (hash_en && chunk == 0 && round == 17) a_r17 = mem_addr;
         if (hash_en && chunk == 1 && round == 0)  a_b2  = mem_addr;
         if (hash_en && !mem_ready) n_frz_bad++;
         if (p_stall && (round != p_round || chunk != p_chunk || mem_read != p_rd ||
                         mem_write != p_wr || digest_sel != p_ds)) n_frz_bad++;
         stall_now = !mem_ready && !chunk_done && !done;
         if (stall_now) n_stall++;
         p_stall = stall_now; p_round = round; p_chunk = chunk;
         p_rd = mem_read; p_wr = mem_write; p_ds = digest_sel;
         if (stop_round >= 0 && hash_en && int'(round) == stop_round) break;
      end
      start = 1'b0;
   endtask

   initial begin
      int n;
      // Reset state
      #1 reset_en = 1'b0;
      @(negedge clk);
      chk("rst_outs", all_outs, 64'd0);
      @(posedge clk); #1;

      // MD5, one block, started on the first clock after reset release
      reset_en = 1'b1;
      launch(2'b00, 16'h0100, 16'h0200, 16'd1);
      run_job(1'b0, -1);
      chk("md5_timeout", busy, 0);
      chk("md5_load_rd", c1_rd, 1);
      chk("md5_load_he", c1_he, 0);
      chk("md5_hash_cnt", n_hash, 64);
      chk("md5_r17_addr", a_r17, 16'h0106);
      chk("md5_chunk_done", n_cd, 1);
      chk("md5_wr_cnt", n_wr, 4);
      chk("md5_wr_first", first_wr, 16'h0200);
      chk("md5_wr_last", last_wr, 16'h0203);
      chk("md5_done_cnt", n_done, 1);
      chk("md5_no_err", n_err, 0);
      chk("md5_busy_cyc", n_busy, 71);
      chk("md5_idle_outs", all_outs, 64'd0);

      // SHA1, two blocks
      @(posedge clk); #1;
      launch(2'b01, 16'h0100, 16'h0300, 16'd2);
      run_job(1'b0, -1);
      chk("sha1_hash_cnt", n_hash, 160);
      chk("sha1_rd_acc", n_rd_acc, 32);
      chk("sha1_rd_hi", n_rd_hi, 0);
      chk("sha1_b2_addr", a_b2, 16'h0110);
      chk("sha1_chunk_done", n_cd, 2);
      chk("sha1_wr_cnt", n_wr, 5);
      chk("sha1_wr_last", last_wr, 16'h0304);
      chk("sha1_busy_cyc", n_busy, 170);

      // SHA256 with mem_ready toggling: ideal 75 cycles, 64+7 stall cycles
      @(posedge clk); #1;
      launch(2'b10, 16'h0040, 16'h0400, 16'd1);
      run_job(1'b1, -1);
      chk("sha256_hash_cnt", n_hash, 64);
      chk("sha256_stalls", n_stall, 71);
      chk("sha256_frozen", n_frz_bad, 0);
      chk("sha256_wr_cnt", n_wr, 8);
      chk("sha256_wr_last", last_wr, 16'h0407);
      chk("sha256_busy_cyc", n_busy, 75 + n_stall);
      chk("sha256_done_cnt", n_done, 1);

      // Reserved opcode
      @(posedge clk); #1;
      opcode = 2'b11; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("rsvd_err", err, 1);
      chk("rsvd_busy", busy, 0);
      @(negedge clk);
      chk("rsvd_err_pulse", err, 0);

      // num_blocks = 0: straight to the digest write
      @(posedge clk); #1;
      launch(2'b10, 16'h0040, 16'h0500, 16'd0);
      run_job(1'b0, -1);
      chk("nb0_first_wr_state", c1_wr, 1);
      chk("nb0_hash_cnt", n_hash, 0);
      chk("nb0_wr_cnt", n_wr, 8);
      chk("nb0_wr_first", first_wr, 16'h0500);
      chk("nb0_busy_cyc", n_busy, 9);
      chk("nb0_done_cnt", n_done, 1);

      // Abort at round 30
      @(posedge clk); #1;
      launch(2'b00, 16'h0100, 16'h0200, 16'd1);
      run_job(1'b0, 30);
      chk("abort_reach_r30", round, 30);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      chk("abort_outs", all_outs, 64'd0);
      n = 0;
      repeat (4) begin
         @(negedge clk);
         if (done || busy) n++;
      end
      chk("abort_quiet", n, 0);

      // Reset mid-job at round 40, then a clean job
      @(posedge clk); #1;
      launch(2'b00, 16'h0100, 16'h0200, 16'd1);
      run_job(1'b0, 40);
      chk("rst_reach_r40", round, 40);
      reset_en = 1'b0;
      #1;
      chk("rst_mid_outs", all_outs, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      reset_en = 1'b1;
      launch(2'b00, 16'h0100, 16'h0200, 16'd1);
      run_job(1'b0, -1);
      chk("post_rst_hash", n_hash, 64);
      chk("post_rst_done", n_done, 1);
      chk("post_rst_busy", n_busy, 71);

      // Address wrap at the top of memory
      @(posedge clk); #1;
      launch(2'b10, 16'hFFF8, 16'h0600, 16'd1);
      run_job(1'b0, -1);
      chk("wrap_r0", a_r0, 16'hFFF8);
      chk("wrap_r8", a_r8, 16'h0000);
      chk("wrap_r15", a_r15, 16'h0007);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
